// File: rtl/line_ram_ctrl.sv
// -----------------------------------------------------------------------------
// line_ram_ctrl
// Line-wide RAM controller: one request port (read or byte-masked write of a
// whole line), one programming port (single word written into a line) and an
// in-order read response FIFO with ready/valid back-pressure. An optional
// clear pass zeroes every line after reset.
//
// Ports
//   clk_i          single clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    request valid          req_ready_o  request accepted
//   req_we_i       1 = write, 0 = read    req_addr_i   line address
//   req_wdata_i    write line data        req_wstrb_i  write byte enables
//   rsp_valid_o    response FIFO non-empty
//   rsp_ready_i    response consumer ready
//   rsp_rdata_o    response FIFO head line
//   prog_valid_i   programming word valid prog_ready_o programming accepted
//   prog_addr_i    word address           prog_data_i  programming word
//   init_done_o    memory usable (RUN state)
// -----------------------------------------------------------------------------
module line_ram_ctrl #(
    parameter int LINE_WIDTH     = 128,
    parameter int WORD_WIDTH     = 32,
    parameter int DEPTH_LINES    = 8192,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 0,
    localparam int WPL = LINE_WIDTH / WORD_WIDTH,
    localparam int AW  = $clog2(DEPTH_LINES),
    localparam int PW  = AW + $clog2(WPL),
    localparam int FD  = READ_LATENCY + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [AW-1:0]           req_addr_i,
    input  logic [LINE_WIDTH-1:0]   req_wdata_i,
    input  logic [LINE_WIDTH/8-1:0] req_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [LINE_WIDTH-1:0]   rsp_rdata_o,
    input  logic                    prog_valid_i,
    output logic                    prog_ready_o,
    input  logic [PW-1:0]           prog_addr_i,
    input  logic [WORD_WIDTH-1:0]   prog_data_i,
    output logic                    init_done_o
);

    localparam int NB   = LINE_WIDTH / 8;
    localparam int BPW  = WORD_WIDTH / 8;
    localparam int SW   = $clog2(WPL);
    localparam int PTRW = (FD > 2) ? 2 : 1;
    localparam int CW   = 3;

    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH_LINES);
    localparam logic [AW-1:0] CLR_LAST  = AW'(DEPTH_LINES - 1);
    localparam logic [PW-1:0] WORD_MASK = PW'(WPL - 1);

    generate
        if (((LINE_WIDTH % WORD_WIDTH) != 0) || ((WORD_WIDTH % 8) != 0) ||
            (WPL < 1) || ((WPL & (WPL - 1)) != 0) ||
            ((READ_LATENCY != 1) && (READ_LATENCY != 2))) begin : g_bad_params
            $error("line_ram_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [AW-1:0]           clr_addr_r;
    logic [AW-1:0]           clr_addr_nxt_s;

    logic                    run_s;
    logic                    prog_acc_s;
    logic                    req_acc_s;
    logic                    wr_acc_s;
    logic                    rd_acc_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    inflight_s;
    logic [CW-1:0]           occ_s;

    logic [AW-1:0]           prog_line_s;
    logic [PW-1:0]           prog_word_s;
    logic [NB-1:0]           prog_be_s;

    logic                    mem_we_s;
    logic [AW-1:0]           mem_waddr_s;
    logic [LINE_WIDTH-1:0]   mem_wdata_s;
    logic [NB-1:0]           mem_be_s;
    logic                    waddr_ok_s;
    logic                    raddr_ok_s;
    logic [LINE_WIDTH-1:0]   rd_line_s;
    logic [LINE_WIDTH-1:0]   push_data_s;

    logic [LINE_WIDTH-1:0]   mem_r  [DEPTH_LINES];
    logic [LINE_WIDTH-1:0]   fifo_r [FD];
    logic [PTRW-1:0]         wptr_r;
    logic [PTRW-1:0]         rptr_r;
    logic [1:0]              cnt_r;

    // FIFO pointers wrap at FD, which need not be a power of two.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        if (p == PTRW'(FD - 1)) begin
            return {PTRW{1'b0}};
        end else begin
            return p + PTRW'(1);
        end
    endfunction

    // State register; reset picks the post-reset state directly so the first
    // cycle after release is already CLEAR or RUN.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_addr_r <= {AW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            clr_addr_r <= clr_addr_nxt_s;
        end
    end

    // Next-state logic: CLEAR walks every line once, then RUN forever.
    always_comb begin
        state_nxt_s    = state_r;
        clr_addr_nxt_s = clr_addr_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_addr_r == CLR_LAST) begin
                    state_nxt_s    = ST_RUN;
                    clr_addr_nxt_s = {AW{1'b0}};
                end else begin
                    state_nxt_s    = ST_CLEAR;
                    clr_addr_nxt_s = clr_addr_r + AW'(1);
                end
            end
            ST_RUN: begin
                state_nxt_s    = ST_RUN;
                clr_addr_nxt_s = {AW{1'b0}};
            end
            default: begin
                state_nxt_s    = ST_RUN;
                clr_addr_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // Handshakes are gated by rst_i so nothing is accepted while reset is held.
    assign run_s        = (state_r == ST_RUN) && !rst_i;
    assign prog_ready_o = run_s;
    assign init_done_o  = (state_r == ST_RUN);
    assign prog_acc_s   = prog_valid_i && run_s;

    assign rsp_valid_o  = (cnt_r != 2'd0);
    assign rsp_rdata_o  = fifo_r[rptr_r];
    assign pop_s        = rsp_valid_o && rsp_ready_i;

    // Every accepted read owns a FIFO slot from accept until pop, so
    // occupancy counts reads still in the pipeline plus stored entries.
    assign occ_s        = CW'(inflight_s) + CW'(cnt_r) - CW'(pop_s);
    assign req_ready_o  = run_s && !prog_valid_i && (occ_s < CW'(FD));
    assign req_acc_s    = req_valid_i && req_ready_o;
    assign wr_acc_s     = req_acc_s && req_we_i;
    assign rd_acc_s     = req_acc_s && !req_we_i;

    assign prog_line_s  = AW'(prog_addr_i >> SW);
    assign prog_word_s  = prog_addr_i & WORD_MASK;

    // Byte enables covering the addressed word slot of the line.
    always_comb begin
        prog_be_s = {NB{1'b0}};
        for (int b = 0; b < NB; b++) begin
            if ((b / BPW) == int'(prog_word_s)) begin
                prog_be_s[b] = 1'b1;
            end else begin
                prog_be_s[b] = 1'b0;
            end
        end
    end

    // Single write port: clear, then programming, then request write.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {AW{1'b0}};
        mem_wdata_s = {LINE_WIDTH{1'b0}};
        mem_be_s    = {NB{1'b0}};
        if ((state_r == ST_CLEAR) && !rst_i) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_addr_r;
            mem_wdata_s = {LINE_WIDTH{1'b0}};
            mem_be_s    = {NB{1'b1}};
        end else if (prog_acc_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = prog_line_s;
            mem_wdata_s = {WPL{prog_data_i}};
            mem_be_s    = prog_be_s;
        end else if (wr_acc_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = req_addr_i;
            mem_wdata_s = req_wdata_i;
            mem_be_s    = req_wstrb_i;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = {AW{1'b0}};
            mem_wdata_s = {LINE_WIDTH{1'b0}};
            mem_be_s    = {NB{1'b0}};
        end
    end

    assign waddr_ok_s = ({1'b0, mem_waddr_s} < DEPTH_C);
    assign raddr_ok_s = ({1'b0, req_addr_i} < DEPTH_C);

    // Line storage; deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (mem_we_s && waddr_ok_s) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be_s[b]) begin
                    mem_r[mem_waddr_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    // Read data for the current request; out-of-range lines read as zero.
    always_comb begin
        rd_line_s = {LINE_WIDTH{1'b0}};
        if (raddr_ok_s) begin
            rd_line_s = mem_r[req_addr_i];
        end else begin
            rd_line_s = {LINE_WIDTH{1'b0}};
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            // Data is captured into the FIFO on the accepting edge.
            assign push_s      = rd_acc_s;
            assign push_data_s = rd_line_s;
            assign inflight_s  = 1'b0;
        end else begin : g_lat2
            logic                  stg_vld_r;
            logic [LINE_WIDTH-1:0] stg_data_r;

            // One extra pipeline stage between the RAM read and the FIFO.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    stg_vld_r  <= 1'b0;
                    stg_data_r <= {LINE_WIDTH{1'b0}};
                end else begin
                    stg_vld_r  <= rd_acc_s;
                    stg_data_r <= rd_line_s;
                end
            end

            assign push_s      = stg_vld_r;
            assign push_data_s = stg_data_r;
            assign inflight_s  = stg_vld_r;
        end
    endgenerate

    // FIFO pointers and count; reset drops everything in flight and stored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_r <= {PTRW{1'b0}};
            rptr_r <= {PTRW{1'b0}};
            cnt_r  <= 2'd0;
        end else begin
            if (push_s) begin
                wptr_r <= ptr_inc(wptr_r);
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end
            cnt_r <= cnt_r + 2'(push_s) - 2'(pop_s);
        end
    end

    // FIFO storage; an occupied entry is never rewritten, so the head is stable.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_r[wptr_r] <= push_data_s;
        end
    end

endmodule

// File: tb/tb_line_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_ram_ctrl
// Two instances: A (READ_LATENCY=1, DEPTH_LINES=12, no clear) and
// B (READ_LATENCY=2, DEPTH_LINES=16, clear on reset). A line model per
// instance produces expected read data, pushed to a queue on read accept and
// compared when the response is popped.
// -----------------------------------------------------------------------------
module tb_line_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int pops_b      = 0;

    // Instance A signals
    logic         a_rst, a_req_valid, a_req_ready, a_req_we;
    logic [3:0]   a_req_addr;
    logic [127:0] a_req_wdata;
    logic [15:0]  a_req_wstrb;
    logic         a_rsp_valid, a_rsp_ready;
    logic [127:0] a_rsp_rdata;
    logic         a_prog_valid, a_prog_ready;
    logic [5:0]   a_prog_addr;
    logic [31:0]  a_prog_data;
    logic         a_init_done;

    // Instance B signals
    logic         b_rst, b_req_valid, b_req_ready, b_req_we;
    logic [3:0]   b_req_addr;
    logic [127:0] b_req_wdata;
    logic [15:0]  b_req_wstrb;
    logic         b_rsp_valid, b_rsp_ready;
    logic [127:0] b_rsp_rdata;
    logic         b_prog_valid, b_prog_ready;
    logic [5:0]   b_prog_addr;
    logic [31:0]  b_prog_data;
    logic         b_init_done;

    logic [127:0] model_a [16];
    logic [127:0] model_b [16];
    logic [127:0] q_a [$];
    logic [127:0] q_b [$];

    line_ram_ctrl #(
        .LINE_WIDTH(128), .WORD_WIDTH(32), .DEPTH_LINES(12),
        .READ_LATENCY(1), .CLEAR_ON_RESET(0)
    ) dut_a (
        .clk_i(clk), .rst_i(a_rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_we_i(a_req_we), .req_addr_i(a_req_addr),
        .req_wdata_i(a_req_wdata), .req_wstrb_i(a_req_wstrb),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
        .prog_valid_i(a_prog_valid), .prog_ready_o(a_prog_ready),
        .prog_addr_i(a_prog_addr), .prog_data_i(a_prog_data),
        .init_done_o(a_init_done)
    );

    line_ram_ctrl #(
        .LINE_WIDTH(128), .WORD_WIDTH(32), .DEPTH_LINES(16),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk_i(clk), .rst_i(b_rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_we_i(b_req_we), .req_addr_i(b_req_addr),
        .req_wdata_i(b_req_wdata), .req_wstrb_i(b_req_wstrb),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .prog_valid_i(b_prog_valid), .prog_ready_o(b_prog_ready),
        .prog_addr_i(b_prog_addr), .prog_data_i(b_prog_data),
        .init_done_o(b_init_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] merge(input logic [127:0] old_line,
                                           input logic [127:0] d,
                                           input logic [15:0] be);
        logic [127:0] r;
        r = old_line;
        for (int b = 0; b < 16; b++) begin
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Scoreboard for A: pop/compare first, then record newly accepted traffic.
    always @(negedge clk) begin
        if (!a_rst) begin
            if (a_rsp_valid && a_rsp_ready) begin
                chk("a_rsp_expected", 128'(q_a.size() != 0), 128'd1);
                if (q_a.size() != 0) chk("a_rsp_data", a_rsp_rdata, q_a.pop_front());
            end
            if (a_req_valid && a_req_ready) begin
                if (a_req_we) begin
                    if (a_req_addr < 4'd12)
                        model_a[a_req_addr] = merge(model_a[a_req_addr], a_req_wdata, a_req_wstrb);
                end else begin
                    q_a.push_back((a_req_addr < 4'd12) ? model_a[a_req_addr] : 128'd0);
                end
            end
            if (a_prog_valid && a_prog_ready) begin
                if (a_prog_addr[5:2] < 4'd12)
                    model_a[a_prog_addr[5:2]] = merge(model_a[a_prog_addr[5:2]],
                        {4{a_prog_data}}, 16'h000F << (4 * a_prog_addr[1:0]));
            end
        end
    end

    // Scoreboard for B (all 16 lines in range, no programming traffic).
    always @(negedge clk) begin
        if (!b_rst) begin
            if (b_rsp_valid && b_rsp_ready) begin
                pops_b++;
                chk("b_rsp_expected", 128'(q_b.size() != 0), 128'd1);
                if (q_b.size() != 0) chk("b_rsp_data", b_rsp_rdata, q_b.pop_front());
            end
            if (b_req_valid && b_req_ready) begin
                if (b_req_we) model_b[b_req_addr] = merge(model_b[b_req_addr], b_req_wdata, b_req_wstrb);
                else q_b.push_back(model_b[b_req_addr]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on A starting at posedge+1; returns at the next posedge+1.
    task automatic a_issue(input logic we, input logic [3:0] addr,
                           input logic [127:0] d, input logic [15:0] s);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_wdata = d; a_req_wstrb = s;
        @(negedge clk);
        chk("a_req_ready", 128'(a_req_ready), 128'd1);
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic b_issue(input logic we, input logic [3:0] addr,
                           input logic [127:0] d, input logic [15:0] s);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
        b_req_wdata = d; b_req_wstrb = s;
        @(negedge clk);
        chk("b_req_ready", 128'(b_req_ready), 128'd1);
        step();
        b_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int cnt;
        a_rst = 1'b1; b_rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 4'd0;
        a_req_wdata = 128'd0; a_req_wstrb = 16'd0; a_rsp_ready = 1'b1;
        a_prog_valid = 1'b0; a_prog_addr = 6'd0; a_prog_data = 32'd0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 4'd0;
        b_req_wdata = 128'd0; b_req_wstrb = 16'd0; b_rsp_ready = 1'b1;
        b_prog_valid = 1'b0; b_prog_addr = 6'd0; b_prog_data = 32'd0;
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 128'd0;
            model_b[i] = 128'd0;
        end

        // Outputs while reset is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_req_ready", 128'(a_req_ready), 128'd0);
        chk("rst_a_prog_ready", 128'(a_prog_ready), 128'd0);
        chk("rst_a_rsp_valid", 128'(a_rsp_valid), 128'd0);
        chk("rst_a_init_done", 128'(a_init_done), 128'd1);
        chk("rst_b_init_done", 128'(b_init_done), 128'd0);
        chk("rst_b_req_ready", 128'(b_req_ready), 128'd0);
        step();
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        chk("b_first_cycle_clear", 128'(b_init_done), 128'd0);
        chk("b_clear_prog_ready", 128'(b_prog_ready), 128'd0);
        chk("a_first_cycle_run", 128'(a_init_done), 128'd1);
        step();

        // A: fill every in-range line, then write out-of-range line 13
        for (int i = 0; i < 12; i++)
            a_issue(1'b1, 4'(i), {4{32'h0101_0101 * (i + 1)}}, 16'hFFFF);
        a_issue(1'b1, 4'd13, {128{1'b1}}, 16'hFFFF);

        // A: full write, single-byte write, read back one cycle later
        a_issue(1'b1, 4'd5, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF);
        a_issue(1'b1, 4'd5, 128'h0000_00AA, 16'h0001);
        a_issue(1'b0, 4'd5, 128'd0, 16'd0);
        @(negedge clk);
        chk("a_lat1_valid", 128'(a_rsp_valid), 128'd1);
        chk("a_strb_merge", a_rsp_rdata, 128'h0F0E0D0C_0B0A0908_07060504_030201AA);
        step();

        // A: programming write beats a simultaneous read request
        a_prog_valid = 1'b1; a_prog_addr = 6'h16; a_prog_data = 32'hDEADBEEF;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 4'd5;
        @(negedge clk);
        chk("a_prog_blocks_req", 128'(a_req_ready), 128'd0);
        chk("a_prog_ready", 128'(a_prog_ready), 128'd1);
        step();
        a_prog_valid = 1'b0;
        @(negedge clk);
        chk("a_req_ready_after_prog", 128'(a_req_ready), 128'd1);
        step();
        a_req_valid = 1'b0;
        @(negedge clk);
        chk("a_prog_valid_rsp", 128'(a_rsp_valid), 128'd1);
        chk("a_prog_word", a_rsp_rdata, 128'h0F0E0D0C_DEADBEEF_07060504_030201AA);
        step();

        // A: out-of-range read returns zero
        a_issue(1'b0, 4'd13, 128'd0, 16'd0);
        @(negedge clk);
        chk("a_oob_read_zero", a_rsp_rdata, 128'd0);
        step();

        // A: random mixed traffic, then read every line back
        repeat (40) a_issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 13)),
                            {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
        for (int i = 0; i < 14; i++) a_issue(1'b0, 4'(i), 128'd0, 16'd0);
        repeat (3) step();
        chk("a_all_responses_seen", 128'(q_a.size()), 128'd0);

        // B: wait for the power-up clear, then preload nonzero contents
        for (int k = 0; k < 64 && !b_init_done; k++) step();
        chk("b_init_done", 128'(b_init_done), 128'd1);
        for (int i = 0; i < 16; i++)
            b_issue(1'b1, 4'(i), {4{32'hB000_0000 + 32'(i)}}, 16'hFFFF);

        // B: five back-to-back reads with the consumer stalled
        b_rsp_ready = 1'b0; acc = 0; pops_b = 0;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 4'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b_req_ready) acc++;
            step();
            if (acc < 5) b_req_addr = 4'(acc);
            else b_req_valid = 1'b0;
        end
        @(negedge clk);
        chk("b_stall_accepts", 128'(acc), 128'd3);
        chk("b_stall_valid", 128'(b_rsp_valid), 128'd1);
        chk("b_stall_head_hold", b_rsp_rdata, model_b[0]);
        step();
        b_rsp_ready = 1'b1;
        for (int k = 0; k < 20 && acc < 5; k++) begin
            @(negedge clk);
            if (b_req_ready && b_req_valid) acc++;
            step();
            if (acc < 5) b_req_addr = 4'(acc);
            else b_req_valid = 1'b0;
        end
        b_req_valid = 1'b0;
        for (int k = 0; k < 20 && pops_b < 5; k++) step();
        chk("b_all_accepted", 128'(acc), 128'd5);
        chk("b_all_popped", 128'(pops_b), 128'd5);
        chk("b_queue_empty", 128'(q_b.size()), 128'd0);

        // B: asynchronous reset with one response stored and one read in flight
        b_rsp_ready = 1'b0;
        b_issue(1'b0, 4'd6, 128'd0, 16'd0);
        b_issue(1'b0, 4'd7, 128'd0, 16'd0);
        #1;
        chk("b_pre_reset_valid", 128'(b_rsp_valid), 128'd1);
        b_rst = 1'b1;
        #1;
        chk("b_async_rst_valid", 128'(b_rsp_valid), 128'd0);
        chk("b_rst_req_ready", 128'(b_req_ready), 128'd0);
        chk("b_rst_init_done", 128'(b_init_done), 128'd0);
        q_b.delete();
        for (int i = 0; i < 16; i++) model_b[i] = 128'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        b_rsp_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b_init_done) break;
            cnt++;
        end
        chk("b_clear_cycles", 128'(cnt), 128'd16);
        step();
        for (int i = 0; i < 16; i++) b_issue(1'b0, 4'(i), 128'd0, 16'd0);
        repeat (4) step();
        chk("b_clear_reads_done", 128'(q_b.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
